// File: rtl/wts_slot_bus_decoder.sv
// Slot bus front end: synchronises the cartridge slot strobes, turns each
// memory access into a single bus transaction and drives read data back.
module wts_slot_bus_decoder #(
    parameter int unsigned READ_TIMEOUT = 16,
    parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        slot_nreset,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    input  logic        slot_nsltsl,
    input  logic        slot_nmerq,
    input  logic        slot_nrd,
    input  logic        slot_nwr,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ready,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_WAIT = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;

    localparam int unsigned       CW      = $clog2(READ_TIMEOUT + 1);
    localparam logic [CW-1:0]     TO_LAST = CW'(READ_TIMEOUT - 1);

    // Strobe vector order: {nsltsl, nmerq, nrd, nwr}
    logic [3:0]    sync1, sync2;
    logic [1:0]    fill;
    logic          armed;
    logic [1:0]    state;
    logic          drive;
    logic [CW-1:0] timeout_cnt;
    logic          access;

    assign access = !sync2[3] && !sync2[2] && (!sync2[1] || !sync2[0]);

    assign slot_d_oe = drive && !slot_nrd && !slot_nsltsl;

    always_ff @(posedge clk) begin
        if (!slot_nreset) begin
            sync1       <= '1;
            sync2       <= '1;
            fill        <= '0;
            armed       <= 1'b0;
            state       <= IDLE;
            drive       <= 1'b0;
            timeout_cnt <= '0;
            bus_valid   <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= '0;
            bus_wdata   <= '0;
            slot_d_out  <= '0;
        end else begin
            sync1     <= {slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr};
            sync2     <= sync1;
            fill      <= {fill[0], 1'b1};
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            // Arm only once the synchroniser holds post-reset samples, so a
            // strobe held low across reset must be seen high before it counts.
            if (fill[1] && !access)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (access && armed) begin
                        bus_valid   <= 1'b1;
                        bus_address <= slot_a;
                        if (!sync2[0]) begin
                            bus_write <= 1'b1;
                            bus_wdata <= slot_d_in;
                            state     <= HOLD;
                        end else begin
                            timeout_cnt <= '0;
                            state       <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (!access) begin
                        drive <= 1'b0;
                        state <= IDLE;
                    end else if (bus_ready) begin
                        if (bus_rdata_en) begin
                            slot_d_out <= bus_rdata;
                            drive      <= 1'b1;
                        end
                        state <= HOLD;
                    end else if (timeout_cnt == TO_LAST) begin
                        slot_d_out <= TIMEOUT_DATA;
                        drive      <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        timeout_cnt <= timeout_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (!access) begin
                        drive <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
